paddle_ctrl: RTL and testbench
==============================

PADDLE_CTRL -- requirements
Module: paddle_ctrl

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- WIDTH, 10, coordinate width.
- Y_MIN, 28, topmost legal y_top.
- Y_MAX, 473, bottommost legal y_bot.
- HEIGHT, 40, paddle height, y_bot - y_top.
- Y_START, 220, y_top after reset/restart.
- TICK_DIV, 200000, clock cycles per movement tick.
- STEP, 3, base pixels per tick.
- STEP_MAX, 9, step ceiling.
- RAMP_TICKS, 8, consecutive same-direction moves per step increase.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clock, in, 1, clock.
- reset, in, 1, reset, synchronous, active-low.
- up_n, in, 1, up button, active-low, asynchronous to clock.
- down_n, in, 1, down button, active-low, asynchronous to clock.
- restart, in, 1, active-high round restart pulse.
- enable, in, 1, movement enable.
- y_top, out, WIDTH, paddle top edge.
- y_bot, out, WIDTH, paddle bottom edge.
- moving, out, 1, paddle moved on the last tick.
- at_limit, out, 1, paddle touching Y_MIN or Y_MAX.

Function
REQ-003 up_n and down_n SHALL each pass through a 2-flop synchronizer; only synchronized values are used.
REQ-004 A tick counter SHALL count 0..TICK_DIV-1 and wrap; the tick is asserted for one cycle when the count equals TICK_DIV-1.
REQ-005 The FSM SHALL have states IDLE, UP and DOWN, and SHALL update only on tick cycles.
REQ-006 On a tick, the next state SHALL be:
- UP if only up is pressed.
- DOWN if only down is pressed.
- IDLE if neither or both are pressed.
REQ-007 On a tick entering or staying in UP, y_top SHALL become max(y_top - step, Y_MIN); for DOWN, y_bot SHALL become min(y_bot + step, Y_MAX).
REQ-008 Invariant: y_bot SHALL equal y_top + HEIGHT on every cycle; clamp arithmetic SHALL be evaluated at WIDTH+1 bits so no underflow or overflow wrap occurs.
REQ-009 moving SHALL be 1 after a tick in which y_top changed, else 0; at the limit with the button held, moving SHALL be 0 and the state SHALL remain UP/DOWN.
REQ-010 at_limit SHALL be 1 exactly when y_top == Y_MIN or y_bot == Y_MAX, updated in the same cycle as the position.
REQ-011 Direction change (UP<->DOWN) SHALL be direct, without passing through IDLE, and SHALL reload step to STEP.
REQ-012 When enable = 0: position held, FSM forced to IDLE, tick counter held at 0, moving = 0.
REQ-013 restart = 1 SHALL, on the next edge:
- load y_top = Y_START and y_bot = Y_START + HEIGHT.
- set FSM = IDLE, step = STEP, ramp counter = 0, tick counter = 0, moving = 0.
REQ-014 restart SHALL take priority over enable and buttons; reset SHALL take priority over restart.
REQ-015 All outputs SHALL be registered; a button change SHALL affect position at the first tick at least 2 cycles after the change.

Reset
REQ-016 When reset = 0 at a clock edge, the block SHALL load:
- y_top = Y_START, y_bot = Y_START + HEIGHT.
- moving = 0, at_limit = 0 (unless Y_START is at a limit).
- FSM = IDLE, step = STEP, ramp and tick counters = 0.
- synchronizers = 1.
REQ-017 Reset asserted mid-move SHALL abort the move with no partial update.
REQ-018 Y_START >= Y_MIN and Y_START + HEIGHT <= Y_MAX SHALL hold; violation is a parameter error.

Configuration
REQ-019 With macro PADDLE_ACCEL_EN defined:
- Each actual move increments the ramp counter.
- On reaching RAMP_TICKS, step SHALL become min(step + STEP, STEP_MAX) and the ramp counter clears.
- IDLE, direction change, a blocked move at a limit, or enable = 0 reload step to STEP and clear the ramp counter.
REQ-020 Without PADDLE_ACCEL_EN, step SHALL be constant STEP and no ramp counter SHALL be synthesized.

Verification (bench: TICK_DIV = 4, STEP = 3, STEP_MAX = 9, RAMP_TICKS = 4, Y_MAX = 471)
REQ-021 reset = 0 for 2 cycles, then released -> y_top = 220, y_bot = 260, moving = 0, at_limit = 0.
REQ-022 Accel off, up_n = 0 for 10 ticks -> y_top = 190, y_bot = 230; held until the limit -> y_top = 28, at_limit = 1, moving = 0 thereafter.
REQ-023 Accel off, down_n = 0 held -> after tick 70, y_bot = 470; at tick 71 clamped to y_bot = 471, y_top = 431, at_limit = 1.
REQ-024 up_n = down_n = 0 for 5 ticks -> position unchanged at 220/260, moving = 0.
REQ-025 restart pulse during a DOWN move at y_top = 250 -> next cycle y_top = 220, y_bot = 260; the following move uses step 3.
REQ-026 PADDLE_ACCEL_EN, down_n = 0 for 12 ticks -> steps 3,3,3,3,6,6,6,6,9,9,9,9 -> y_top = 292, y_bot = 332.

Source files
------------

// File: rtl/paddle_ctrl.sv
// paddle_ctrl: debounced-free button paddle mover with tick-paced FSM.
// Optional step acceleration when PADDLE_ACCEL_EN is defined.
module paddle_ctrl #(
  parameter int WIDTH      = 10,
  parameter int Y_MIN      = 28,
  parameter int Y_MAX      = 473,
  parameter int HEIGHT     = 40,
  parameter int Y_START    = 220,
  parameter int TICK_DIV   = 200000,
  parameter int STEP       = 3,
  parameter int STEP_MAX   = 9,
  parameter int RAMP_TICKS = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             up_n,
  input  logic             down_n,
  input  logic             restart,
  input  logic             enable,
  output logic [WIDTH-1:0] y_top,
  output logic [WIDTH-1:0] y_bot,
  output logic             moving,
  output logic             at_limit
);

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  localparam int EW = WIDTH + 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [EW-1:0] E_MIN = EW'(Y_MIN);
  localparam logic [EW-1:0] E_MAX = EW'(Y_MAX);
  localparam logic [EW-1:0] E_H = EW'(HEIGHT);
  localparam logic [WIDTH-1:0] W_MIN = WIDTH'(Y_MIN);
  localparam logic [WIDTH-1:0] W_MAX = WIDTH'(Y_MAX);
  localparam logic [WIDTH-1:0] W_START = WIDTH'(Y_START);
  localparam logic [WIDTH-1:0] W_SBOT = WIDTH'(Y_START + HEIGHT);
  localparam logic [WIDTH-1:0] W_STEP = WIDTH'(STEP);
  localparam logic START_LIM =
    (Y_START == Y_MIN) || (Y_START + HEIGHT == Y_MAX);

  if (Y_START < Y_MIN || Y_START + HEIGHT > Y_MAX ||
      STEP_MAX < STEP || RAMP_TICKS < 1) begin : g_bad_param
    $error("paddle_ctrl: illegal parameter set");
  end

  logic             r_up_s1, r_up_s2, r_dn_s1, r_dn_s2;
  logic [TW-1:0]    r_tick_cnt;
  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_y_top, r_y_bot;
  logic [WIDTH-1:0] w_top_nxt, w_bot_nxt, w_step;
  logic             r_moving, r_at_limit;
  logic             w_tick, w_up, w_dn, w_rev;
  logic             w_moved, w_lim_nxt;
  logic [EW-1:0]    w_step_e, w_up_cand, w_dn_sum, w_dn_cand;

  assign w_up   = ~r_up_s2;
  assign w_dn   = ~r_dn_s2;
  assign w_tick = enable & (r_tick_cnt == TICK_LAST);
  assign w_rev  = (r_state == UP && w_state_nxt == DOWN) ||
                  (r_state == DOWN && w_state_nxt == UP);

`ifdef PADDLE_ACCEL_EN
  localparam int RW = $clog2(RAMP_TICKS + 1);
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_TICKS);
  localparam logic [EW-1:0] E_STEP = EW'(STEP);
  localparam logic [EW-1:0] E_SMAX = EW'(STEP_MAX);

  logic [WIDTH-1:0] r_step, w_step_nxt;
  logic [RW-1:0]    r_ramp, w_ramp_nxt, w_ramp_inc;
  logic [EW-1:0]    w_step_sum;

  assign w_step = w_rev ? W_STEP : r_step;

  // Ramp step after enough consecutive moves; reload on any stall.
  always_comb begin
    w_step_nxt = r_step;
    w_ramp_nxt = r_ramp;
    w_ramp_inc = (w_rev ? '0 : r_ramp) + RW'(1);
    w_step_sum = {1'b0, w_step} + E_STEP;
    if (!enable || (w_tick && !w_moved)) begin
      w_step_nxt = W_STEP;
      w_ramp_nxt = '0;
    end else if (w_tick) begin
      if (w_ramp_inc == RAMP_LAST) begin
        w_step_nxt = (w_step_sum > E_SMAX) ?
                     WIDTH'(STEP_MAX) : w_step_sum[WIDTH-1:0];
        w_ramp_nxt = '0;
      end else begin
        w_step_nxt = w_step;
        w_ramp_nxt = w_ramp_inc;
      end
    end
  end

  // Step and ramp registers; restart behaves like reset.
  always_ff @(posedge clock) begin
    if (!reset || restart) begin
      r_step <= W_STEP;
      r_ramp <= '0;
    end else begin
      r_step <= w_step_nxt;
      r_ramp <= w_ramp_nxt;
    end
  end
`else
  assign w_step = W_STEP;
`endif

  // Two-flop synchronizers for the asynchronous buttons.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_up_s1 <= 1'b1;
      r_up_s2 <= 1'b1;
      r_dn_s1 <= 1'b1;
      r_dn_s2 <= 1'b1;
    end else begin
      r_up_s1 <= up_n;
      r_up_s2 <= r_up_s1;
      r_dn_s1 <= down_n;
      r_dn_s2 <= r_dn_s1;
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset || restart) r_state <= IDLE;
    else                   r_state <= w_state_nxt;
  end

  // Next state: only tick cycles decide direction.
  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = IDLE;
    end else if (w_tick) begin
      unique case (1'b1)
        (w_up && !w_dn): w_state_nxt = UP;
        (w_dn && !w_up): w_state_nxt = DOWN;
        default:         w_state_nxt = IDLE;
      endcase
    end
  end

  // Clamped candidate positions, one bit wider to avoid wrap.
  always_comb begin
    w_step_e  = {1'b0, w_step};
    w_up_cand = ({1'b0, r_y_top} < E_MIN + w_step_e) ?
                E_MIN : {1'b0, r_y_top} - w_step_e;
    w_dn_sum  = {1'b0, r_y_bot} + w_step_e;
    w_dn_cand = (w_dn_sum > E_MAX) ? E_MAX : w_dn_sum;
    w_top_nxt = r_y_top;
    w_bot_nxt = r_y_bot;
    if (w_tick && w_state_nxt == UP) begin
      w_top_nxt = w_up_cand[WIDTH-1:0];
      w_bot_nxt = WIDTH'(w_up_cand + E_H);
    end else if (w_tick && w_state_nxt == DOWN) begin
      w_bot_nxt = w_dn_cand[WIDTH-1:0];
      w_top_nxt = WIDTH'(w_dn_cand - E_H);
    end
    w_moved   = (w_top_nxt != r_y_top);
    w_lim_nxt = (w_top_nxt == W_MIN) || (w_bot_nxt == W_MAX);
  end

  // Tick divider; parked at zero while disabled.
  always_ff @(posedge clock) begin
    if (!reset || restart || !enable) r_tick_cnt <= '0;
    else if (w_tick)                  r_tick_cnt <= '0;
    else                              r_tick_cnt <= r_tick_cnt + TW'(1);
  end

  // Position and status outputs.
  always_ff @(posedge clock) begin
    if (!reset || restart) begin
      r_y_top    <= W_START;
      r_y_bot    <= W_SBOT;
      r_moving   <= 1'b0;
      r_at_limit <= START_LIM;
    end else begin
      r_y_top    <= w_top_nxt;
      r_y_bot    <= w_bot_nxt;
      r_at_limit <= w_lim_nxt;
      if (!enable)     r_moving <= 1'b0;
      else if (w_tick) r_moving <= w_moved;
    end
  end

  assign y_top    = r_y_top;
  assign y_bot    = r_y_bot;
  assign moving   = r_moving;
  assign at_limit = r_at_limit;

endmodule

// File: tb/tb_paddle_ctrl.sv
// tb_paddle_ctrl: cycle scoreboard plus directed position checks.
// Define PADDLE_ACCEL_EN to exercise the accelerating build.
module tb_paddle_ctrl;

`ifdef PADDLE_ACCEL_EN
  localparam bit ACCEL = 1'b1;
`else
  localparam bit ACCEL = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset, up_n, down_n, restart, enable;
  logic [9:0] y_top, y_bot;
  logic       moving, at_limit;

  int n_chk = 0;
  int n_err = 0;

  logic [21:0] sb[$];

  int m_top, m_cnt, m_st, m_step, m_ramp;
  bit m_mov;
  bit m_su1, m_su2, m_sd1, m_sd2;
  int m_nup = 0;
  int m_ndn = 0;
  int m_nall = 0;

  paddle_ctrl #(
    .TICK_DIV(4), .STEP(3), .STEP_MAX(9),
    .RAMP_TICKS(4), .Y_MAX(471)
  ) dut (
    .clock(clock), .reset(reset),
    .up_n(up_n), .down_n(down_n),
    .restart(restart), .enable(enable),
    .y_top(y_top), .y_bot(y_bot),
    .moving(moving), .at_limit(at_limit)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: one update per clock, expectation queued.
  always @(posedge clock) begin : model
    int top, cnt, st, stp, ramp, nst, nt, s;
    bit mov, pu, pd, lim;
    logic [21:0] e;
    top = m_top; cnt = m_cnt; st = m_st;
    stp = m_step; ramp = m_ramp; mov = m_mov;
    pu = !m_su2;
    pd = !m_sd2;
    if (!reset) begin
      top = 220; cnt = 0; st = 0; stp = 3; ramp = 0; mov = 0;
      m_su1 <= 1; m_su2 <= 1; m_sd1 <= 1; m_sd2 <= 1;
    end else begin
      m_su1 <= up_n; m_su2 <= m_su1;
      m_sd1 <= down_n; m_sd2 <= m_sd1;
      if (restart) begin
        top = 220; cnt = 0; st = 0; stp = 3; ramp = 0; mov = 0;
      end else if (!enable) begin
        cnt = 0; st = 0; stp = 3; ramp = 0; mov = 0;
      end else if (cnt < 3) begin
        cnt++;
      end else begin
        cnt = 0;
        m_nall <= m_nall + 1;
        nst = (pu && !pd) ? 1 : (pd && !pu) ? 2 : 0;
        if (nst == 0) begin
          stp = 3; ramp = 0; mov = 0;
        end else begin
          if (st != 0 && nst != st) begin stp = 3; ramp = 0; end
          s = ACCEL ? stp : 3;
          if (nst == 1) nt = (top - s < 28) ? 28 : top - s;
          else nt = ((top + 40 + s > 471) ? 471 : top + 40 + s) - 40;
          mov = (nt != top);
          if (!mov) begin
            stp = 3; ramp = 0;
          end else begin
            ramp++;
            if (ramp == 4) begin
              stp = (stp + 3 > 9) ? 9 : stp + 3;
              ramp = 0;
            end
          end
          top = nt;
          if (nst == 1) m_nup <= m_nup + 1;
          else          m_ndn <= m_ndn + 1;
        end
        st = nst;
      end
    end
    lim = (top == 28) || (top + 40 == 471);
    m_top <= top; m_cnt <= cnt; m_st <= st;
    m_step <= stp; m_ramp <= ramp; m_mov <= mov;
    e = {10'(top), 10'(top + 40), mov, lim};
    sb.push_back(e);
  end

  // Compare every registered output against the queued expectation.
  always @(negedge clock) begin
    if (sb.size() > 0)
      check("cycle", {10'b0, y_top, y_bot, moving, at_limit},
            {10'b0, sb.pop_front()});
  end

  function automatic int cur(input int sel);
    case (sel)
      0:       return m_nup;
      1:       return m_ndn;
      default: return m_nall;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int target,
                          input string tag);
    int k;
    k = 0;
    while (cur(sel) < target && k < 1000) begin
      @(negedge clock);
      k++;
    end
    if (cur(sel) < target)
      check({tag, "_timeout"}, cur(sel), target);
  endtask

  task automatic pulse_restart();
    @(negedge clock);
    restart = 1'b1;
    @(negedge clock);
    restart = 1'b0;
  endtask

  initial begin : stim
    int b;
    reset = 1'b0; up_n = 1'b1; down_n = 1'b1;
    restart = 1'b0; enable = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rst_top", y_top, 220);
    check("rst_bot", y_bot, 260);
    check("rst_mov", moving, 0);
    check("rst_lim", at_limit, 0);

    up_n = 1'b0; down_n = 1'b0;
    b = m_nall;
    wait_for(2, b + 7, "both");
    check("both_top", y_top, 220);
    check("both_bot", y_bot, 260);
    check("both_mov", moving, 0);

    down_n = 1'b1;
    b = m_nup;
    wait_for(0, b + 10, "up10");
    check("up10_top", y_top, ACCEL ? 166 : 190);
    check("up10_bot", y_bot, ACCEL ? 206 : 230);
    check("up10_mov", moving, 1);
    wait_for(0, b + 70, "uplim");
    check("uplim_top", y_top, 28);
    check("uplim_lim", at_limit, 1);
    check("uplim_mov", moving, 0);

    enable = 1'b0;
    repeat (12) @(negedge clock);
    check("dis_top", y_top, 28);
    check("dis_mov", moving, 0);
    enable = 1'b1;
    up_n = 1'b1;
    pulse_restart();
    check("rs_top", y_top, 220);
    check("rs_bot", y_bot, 260);
    check("rs_lim", at_limit, 0);

`ifdef PADDLE_ACCEL_EN
    down_n = 1'b0;
    b = m_ndn;
    wait_for(1, b + 12, "acc12");
    check("acc12_top", y_top, 292);
    check("acc12_bot", y_bot, 332);
`else
    down_n = 1'b0;
    b = m_ndn;
    wait_for(1, b + 70, "dn70");
    check("dn70_bot", y_bot, 470);
    check("dn70_lim", at_limit, 0);
    wait_for(1, b + 71, "dn71");
    check("dn71_bot", y_bot, 471);
    check("dn71_top", y_top, 431);
    check("dn71_lim", at_limit, 1);

    down_n = 1'b1;
    pulse_restart();
    down_n = 1'b0;
    b = m_ndn;
    wait_for(1, b + 10, "dn10");
    check("dn10_top", y_top, 250);
    pulse_restart();
    check("mid_top", y_top, 220);
    check("mid_bot", y_bot, 260);
    check("mid_mov", moving, 0);
    wait_for(1, b + 11, "after");
    check("after_top", y_top, 223);
    check("after_mov", moving, 1);
`endif

    down_n = 1'b1;
    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
